axi4_reg_slice: RTL and testbench

AXI4_REG_SLICE -- requirements
Module: axi4_reg_slice

---
 rtl/axi4_slice_pkg.sv | 55 +++++
 rtl/axi4_chan_slice.sv | 170 +++++++++++++++++
 rtl/axi4_reg_slice.sv | 132 +++++++++++++
 tb/tb_axi4_reg_slice.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_slice_pkg.sv
// Shared types and payload-width helpers for the AXI4 register slice.
// Payloads are opaque bit vectors; only their widths are defined here.
package axi4_slice_pkg;

    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_FWD    = 2'd1,
        SLICE_REV    = 2'd2,
        SLICE_FULL   = 2'd3
    } slice_mode_e;

    // Occupancy of the two-entry FULL buffer.
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_TWO   = 2'd2
    } full_cnt_e;

    localparam int unsigned AX_LEN_W    = 8;
    localparam int unsigned AX_SIZE_W   = 3;
    localparam int unsigned AX_BURST_W  = 2;
    localparam int unsigned AX_LOCK_W   = 1;
    localparam int unsigned AX_CACHE_W  = 4;
    localparam int unsigned AX_PROT_W   = 3;
    localparam int unsigned AX_QOS_W    = 4;
    localparam int unsigned AX_REGION_W = 4;
    localparam int unsigned RESP_W      = 2;
    localparam int unsigned LAST_W      = 1;

    function automatic int unsigned aw_w(input int unsigned id_w,
                                         input int unsigned addr_w,
                                         input int unsigned user_w);
        return id_w + addr_w + AX_LEN_W + AX_SIZE_W + AX_BURST_W + AX_LOCK_W
             + AX_CACHE_W + AX_PROT_W + AX_QOS_W + AX_REGION_W + user_w;
    endfunction

    function automatic int unsigned w_w(input int unsigned data_w,
                                        input int unsigned user_w,
                                        input bit          wid_en,
                                        input int unsigned id_w);
        return data_w + data_w / 8 + LAST_W + user_w + (wid_en ? id_w : 0);
    endfunction

    function automatic int unsigned b_w(input int unsigned id_w,
                                        input int unsigned user_w);
        return id_w + RESP_W + user_w;
    endfunction

    function automatic int unsigned r_w(input int unsigned id_w,
                                        input int unsigned data_w,
                                        input int unsigned user_w);
        return id_w + data_w + RESP_W + LAST_W + user_w;
    endfunction

endpackage

// File: rtl/axi4_chan_slice.sv
// One valid/ready channel slice; MODE selects bypass, forward register,
// reverse skid register or fully registered two-entry buffer.
module axi4_chan_slice
    import axi4_slice_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter slice_mode_e MODE  = SLICE_FULL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             empty
);

    if (MODE == SLICE_BYPASS) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign m_valid = s_valid;
        assign s_ready = m_ready;
        assign m_data  = s_data;
        assign empty   = 1'b1;

    end else if (MODE == SLICE_FWD) begin : g_fwd
        logic             valid_q;
        logic             valid_d;
        logic [WIDTH-1:0] data_q;
        logic             s_ready_c;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
            end
        end

        always_ff @(posedge clk) begin
            if (s_valid && s_ready_c) begin
                data_q <= s_data;
            end
        end

        // Register refills whenever it is empty or being drained this cycle.
        always_comb begin
            s_ready_c = !valid_q || m_ready;
            valid_d   = valid_q;
            if (s_ready_c) begin
                valid_d = s_valid;
            end
        end

        assign s_ready = s_ready_c;
        assign m_valid = valid_q;
        assign m_data  = data_q;
        assign empty   = !valid_q;

    end else if (MODE == SLICE_REV) begin : g_rev
        logic             skid_full_q;
        logic             skid_full_d;
        logic             s_ready_q;
        logic             s_ready_d;
        logic             skid_load;
        logic [WIDTH-1:0] skid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                skid_full_q <= 1'b0;
                s_ready_q   <= 1'b0;
            end else begin
                skid_full_q <= skid_full_d;
                s_ready_q   <= s_ready_d;
            end
        end

        always_ff @(posedge clk) begin
            if (skid_load) begin
                skid_q <= s_data;
            end
        end

        // A beat accepted while downstream stalls parks in the skid register.
        always_comb begin
            skid_full_d = skid_full_q;
            skid_load   = 1'b0;
            if (skid_full_q) begin
                if (m_ready) begin
                    skid_full_d = 1'b0;
                end
            end else if (s_valid && s_ready_q && !m_ready) begin
                skid_full_d = 1'b1;
                skid_load   = 1'b1;
            end
            s_ready_d = !skid_full_d;
        end

        assign s_ready = s_ready_q;
        assign m_valid = skid_full_q || (s_valid && s_ready_q);
        assign m_data  = skid_full_q ? skid_q : s_data;
        assign empty   = !skid_full_q;

    end else begin : g_full
        full_cnt_e        state_q;
        full_cnt_e        state_d;
        logic             rd_ptr_q;
        logic             rd_ptr_d;
        logic             wr_ptr_q;
        logic             wr_ptr_d;
        logic             s_ready_q;
        logic             s_ready_d;
        logic             m_valid_q;
        logic             m_valid_d;
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] mem_q [2];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q   <= CNT_EMPTY;
                rd_ptr_q  <= 1'b0;
                wr_ptr_q  <= 1'b0;
                s_ready_q <= 1'b0;
                m_valid_q <= 1'b0;
            end else begin
                state_q   <= state_d;
                rd_ptr_q  <= rd_ptr_d;
                wr_ptr_q  <= wr_ptr_d;
                s_ready_q <= s_ready_d;
                m_valid_q <= m_valid_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= s_data;
            end
        end

        // Occupancy FSM; handshake flags are re-derived from the next count.
        always_comb begin
            state_d = state_q;
            push    = s_valid && s_ready_q;
            pop     = m_valid_q && m_ready;
            unique case (state_q)
                CNT_EMPTY: if (push)          state_d = CNT_ONE;
                CNT_ONE: begin
                    if (push && !pop)         state_d = CNT_TWO;
                    else if (pop && !push)    state_d = CNT_EMPTY;
                end
                CNT_TWO:   if (pop)           state_d = CNT_ONE;
                default:                      state_d = CNT_EMPTY;
            endcase
            wr_ptr_d  = wr_ptr_q ^ push;
            rd_ptr_d  = rd_ptr_q ^ pop;
            s_ready_d = (state_d != CNT_TWO);
            m_valid_d = (state_d != CNT_EMPTY);
        end

        assign s_ready = s_ready_q;
        assign m_valid = m_valid_q;
        assign m_data  = mem_q[rd_ptr_q];
        assign empty   = (state_q == CNT_EMPTY);
    end

endmodule

// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: five independent channel slices plus an idle flag
// that is high only when no channel holds a beat.
module axi4_reg_slice
    import axi4_slice_pkg::*;
#(
    parameter int unsigned ID_W    = 16,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 512,
    parameter int unsigned USER_W  = 1,
    parameter bit          WID_EN  = 1'b0,
    parameter slice_mode_e AW_MODE = SLICE_FULL,
    parameter slice_mode_e W_MODE  = SLICE_FULL,
    parameter slice_mode_e B_MODE  = SLICE_FULL,
    parameter slice_mode_e AR_MODE = SLICE_FULL,
    parameter slice_mode_e R_MODE  = SLICE_FULL
) (
    input  logic                                       clk,
    input  logic                                       rst_n,

    input  logic                                       s_aw_valid,
    output logic                                       s_aw_ready,
    input  logic [aw_w(ID_W, ADDR_W, USER_W)-1:0]      s_aw_data,
    output logic                                       m_aw_valid,
    input  logic                                       m_aw_ready,
    output logic [aw_w(ID_W, ADDR_W, USER_W)-1:0]      m_aw_data,

    input  logic                                       s_w_valid,
    output logic                                       s_w_ready,
    input  logic [w_w(DATA_W, USER_W, WID_EN, ID_W)-1:0] s_w_data,
    output logic                                       m_w_valid,
    input  logic                                       m_w_ready,
    output logic [w_w(DATA_W, USER_W, WID_EN, ID_W)-1:0] m_w_data,

    input  logic                                       m_b_valid,
    output logic                                       m_b_ready,
    input  logic [b_w(ID_W, USER_W)-1:0]               m_b_data,
    output logic                                       s_b_valid,
    input  logic                                       s_b_ready,
    output logic [b_w(ID_W, USER_W)-1:0]               s_b_data,

    input  logic                                       s_ar_valid,
    output logic                                       s_ar_ready,
    input  logic [aw_w(ID_W, ADDR_W, USER_W)-1:0]      s_ar_data,
    output logic                                       m_ar_valid,
    input  logic                                       m_ar_ready,
    output logic [aw_w(ID_W, ADDR_W, USER_W)-1:0]      m_ar_data,

    input  logic                                       m_r_valid,
    output logic                                       m_r_ready,
    input  logic [r_w(ID_W, DATA_W, USER_W)-1:0]       m_r_data,
    output logic                                       s_r_valid,
    input  logic                                       s_r_ready,
    output logic [r_w(ID_W, DATA_W, USER_W)-1:0]       s_r_data,

    output logic                                       idle
);

    localparam int unsigned AW_W = aw_w(ID_W, ADDR_W, USER_W);
    localparam int unsigned W_W  = w_w(DATA_W, USER_W, WID_EN, ID_W);
    localparam int unsigned B_W  = b_w(ID_W, USER_W);
    localparam int unsigned R_W  = r_w(ID_W, DATA_W, USER_W);

    logic aw_empty;
    logic w_empty;
    logic b_empty;
    logic ar_empty;
    logic r_empty;

    axi4_chan_slice #(.WIDTH(AW_W), .MODE(AW_MODE)) u_aw (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_aw_valid),
        .s_ready (s_aw_ready),
        .s_data  (s_aw_data),
        .m_valid (m_aw_valid),
        .m_ready (m_aw_ready),
        .m_data  (m_aw_data),
        .empty   (aw_empty)
    );

    axi4_chan_slice #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_w_valid),
        .s_ready (s_w_ready),
        .s_data  (s_w_data),
        .m_valid (m_w_valid),
        .m_ready (m_w_ready),
        .m_data  (m_w_data),
        .empty   (w_empty)
    );

    // Response channels flow downstream-to-upstream.
    axi4_chan_slice #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (m_b_valid),
        .s_ready (m_b_ready),
        .s_data  (m_b_data),
        .m_valid (s_b_valid),
        .m_ready (s_b_ready),
        .m_data  (s_b_data),
        .empty   (b_empty)
    );

    axi4_chan_slice #(.WIDTH(AW_W), .MODE(AR_MODE)) u_ar (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_ar_valid),
        .s_ready (s_ar_ready),
        .s_data  (s_ar_data),
        .m_valid (m_ar_valid),
        .m_ready (m_ar_ready),
        .m_data  (m_ar_data),
        .empty   (ar_empty)
    );

    axi4_chan_slice #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (m_r_valid),
        .s_ready (m_r_ready),
        .s_data  (m_r_data),
        .m_valid (s_r_valid),
        .m_ready (s_r_ready),
        .m_data  (s_r_data),
        .empty   (r_empty)
    );

    assign idle = aw_empty && w_empty && b_empty && ar_empty && r_empty;

endmodule

// File: tb/tb_axi4_reg_slice.sv
// Bench for axi4_reg_slice: queue model of an all-FULL instance checked every
// cycle, plus directed W-channel instances in BYPASS, FWD and REV modes.
module tb_axi4_reg_slice;
    import axi4_slice_pkg::*;

    localparam int unsigned IDW = 4;
    localparam int unsigned ADW = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned UW  = 1;
    localparam int unsigned AWW = aw_w(IDW, ADW, UW);
    localparam int unsigned WW1 = w_w(DW, UW, 1'b1, IDW);
    localparam int unsigned WW0 = w_w(DW, UW, 1'b0, IDW);
    localparam int unsigned BW  = b_w(IDW, UW);
    localparam int unsigned RW  = r_w(IDW, DW, UW);

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic chk_en = 1'b0;

    // Main instance, every channel FULL, W carries wid.
    logic aw_iv, aw_ir, aw_ov, aw_or;
    logic [AWW-1:0] aw_id, aw_od;
    logic w_iv, w_ir, w_ov, w_or;
    logic [WW1-1:0] w_id, w_od;
    logic b_iv, b_ir, b_ov, b_or;
    logic [BW-1:0] b_id, b_od;
    logic ar_iv, ar_ir, ar_ov, ar_or;
    logic [AWW-1:0] ar_id, ar_od;
    logic r_iv, r_ir, r_ov, r_or;
    logic [RW-1:0] r_id, r_od;
    logic idle;

    axi4_reg_slice #(
        .ID_W(IDW), .ADDR_W(ADW), .DATA_W(DW), .USER_W(UW), .WID_EN(1'b1),
        .AW_MODE(SLICE_FULL), .W_MODE(SLICE_FULL), .B_MODE(SLICE_FULL),
        .AR_MODE(SLICE_FULL), .R_MODE(SLICE_FULL)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s_aw_valid(aw_iv), .s_aw_ready(aw_ir), .s_aw_data(aw_id),
        .m_aw_valid(aw_ov), .m_aw_ready(aw_or), .m_aw_data(aw_od),
        .s_w_valid(w_iv), .s_w_ready(w_ir), .s_w_data(w_id),
        .m_w_valid(w_ov), .m_w_ready(w_or), .m_w_data(w_od),
        .m_b_valid(b_iv), .m_b_ready(b_ir), .m_b_data(b_id),
        .s_b_valid(b_ov), .s_b_ready(b_or), .s_b_data(b_od),
        .s_ar_valid(ar_iv), .s_ar_ready(ar_ir), .s_ar_data(ar_id),
        .m_ar_valid(ar_ov), .m_ar_ready(ar_or), .m_ar_data(ar_od),
        .m_r_valid(r_iv), .m_r_ready(r_ir), .m_r_data(r_id),
        .s_r_valid(r_ov), .s_r_ready(r_or), .s_r_data(r_od),
        .idle(idle)
    );

    // W-mode instances: index 0 BYPASS, 1 FWD, 2 REV; no wid.
    logic           wv  [3];
    logic [WW0-1:0] wd  [3];
    logic           wmr [3];
    logic           wmv [3];
    logic [WW0-1:0] wmd [3];
    logic           wsr [3];

    for (genvar g = 0; g < 3; g++) begin : g_w
        logic unused_awr, unused_awv, unused_arr, unused_arv;
        logic unused_bv, unused_br, unused_rv, unused_rr, unused_idle;
        logic [AWW-1:0] unused_awd, unused_ard;
        logic [BW-1:0]  unused_bd;
        logic [RW-1:0]  unused_rd;

        axi4_reg_slice #(
            .ID_W(IDW), .ADDR_W(ADW), .DATA_W(DW), .USER_W(UW), .WID_EN(1'b0),
            .AW_MODE(SLICE_FULL), .W_MODE(slice_mode_e'(g)), .B_MODE(SLICE_FULL),
            .AR_MODE(SLICE_FULL), .R_MODE(SLICE_FULL)
        ) u_wm (
            .clk(clk), .rst_n(rst_n),
            .s_aw_valid(1'b0), .s_aw_ready(unused_awr), .s_aw_data('0),
            .m_aw_valid(unused_awv), .m_aw_ready(1'b0), .m_aw_data(unused_awd),
            .s_w_valid(wv[g]), .s_w_ready(wsr[g]), .s_w_data(wd[g]),
            .m_w_valid(wmv[g]), .m_w_ready(wmr[g]), .m_w_data(wmd[g]),
            .m_b_valid(1'b0), .m_b_ready(unused_br), .m_b_data('0),
            .s_b_valid(unused_bv), .s_b_ready(1'b0), .s_b_data(unused_bd),
            .s_ar_valid(1'b0), .s_ar_ready(unused_arr), .s_ar_data('0),
            .m_ar_valid(unused_arv), .m_ar_ready(1'b0), .m_ar_data(unused_ard),
            .m_r_valid(1'b0), .m_r_ready(unused_rr), .m_r_data('0),
            .s_r_valid(unused_rv), .s_r_ready(1'b0), .s_r_data(unused_rd),
            .idle(unused_idle)
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AWW-1:0] mk_aw(input logic [31:0] addr);
        return {4'h1, addr, 29'h0, 1'b0};
    endfunction

    function automatic logic [BW-1:0] mk_b(input logic [3:0] id);
        return {id, 2'b00, 1'b0};
    endfunction

    function automatic logic [RW-1:0] mk_r(input int n);
        logic [31:0] v;
        v = 32'(n);
        return {v[3:0], v * 32'h9E37_79B9, 2'b01, v[0], 1'b1};
    endfunction

    // Channel views for the model: 0 AW, 1 W, 2 B, 3 AR, 4 R.
    logic         in_v [5];
    logic         in_r [5];
    logic [127:0] in_d [5];
    logic         out_v[5];
    logic         out_r[5];
    logic [127:0] out_d[5];

    always_comb begin
        in_v[0] = aw_iv; in_r[0] = aw_ir; in_d[0] = 128'(aw_id);
        out_v[0] = aw_ov; out_r[0] = aw_or; out_d[0] = 128'(aw_od);
        in_v[1] = w_iv; in_r[1] = w_ir; in_d[1] = 128'(w_id);
        out_v[1] = w_ov; out_r[1] = w_or; out_d[1] = 128'(w_od);
        in_v[2] = b_iv; in_r[2] = b_ir; in_d[2] = 128'(b_id);
        out_v[2] = b_ov; out_r[2] = b_or; out_d[2] = 128'(b_od);
        in_v[3] = ar_iv; in_r[3] = ar_ir; in_d[3] = 128'(ar_id);
        out_v[3] = ar_ov; out_r[3] = ar_or; out_d[3] = 128'(ar_od);
        in_v[4] = r_iv; in_r[4] = r_ir; in_d[4] = 128'(r_id);
        out_v[4] = r_ov; out_r[4] = r_or; out_d[4] = 128'(r_od);
    end

    // Model: each channel is a queue of at most two beats; ready is offered
    // from the first clock after reset while fewer than two beats are held.
    logic [127:0] mq [5][$];
    logic         rdy_en;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < 5; ch++) mq[ch].delete();
            rdy_en <= 1'b0;
        end else begin
            for (int ch = 0; ch < 5; ch++) begin
                automatic int sz = mq[ch].size();
                if (sz != 0 && out_r[ch]) void'(mq[ch].pop_front());
                if (in_v[ch] && rdy_en && sz < 2) mq[ch].push_back(in_d[ch]);
            end
            rdy_en <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic logic all_empty = 1'b1;
            for (int ch = 0; ch < 5; ch++) begin
                automatic int sz = mq[ch].size();
                check($sformatf("model_ch%0d_valid", ch), 128'(out_v[ch]), 128'(sz != 0));
                check($sformatf("model_ch%0d_ready", ch), 128'(in_r[ch]), 128'(rdy_en && sz < 2));
                if (sz != 0) check($sformatf("model_ch%0d_data", ch), out_d[ch], mq[ch][0]);
                if (sz != 0) all_empty = 1'b0;
            end
            check("model_idle", 128'(idle), 128'(all_empty));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW0-1:0] d0, d1;
        int acc, k, lat, sent, recv, maxocc, simul;
        logic inx, outx, accept;
        logic [2:0] exp_lat;

        rst_n = 1'b1;
        aw_iv = 0; aw_id = '0; aw_or = 0; w_iv = 0; w_id = '0; w_or = 0;
        b_iv = 0; b_id = '0; b_or = 0; ar_iv = 0; ar_id = '0; ar_or = 0;
        r_iv = 0; r_id = '0; r_or = 0;
        for (int i = 0; i < 3; i++) begin wv[i] = 0; wd[i] = '0; wmr[i] = 0; end

        // Reset state and release
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_idle", 128'(idle), 128'(1));
        check("rst_aw_m_valid", 128'(aw_ov), 128'(0));
        check("rst_aw_s_ready", 128'(aw_ir), 128'(0));
        check("rst_r_s_valid", 128'(r_ov), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rel_ready_before_edge", 128'(aw_ir), 128'(0));
        tick();
        check("rel_ready_after_edge", 128'(aw_ir), 128'(1));

        // 8 back-to-back AW beats, downstream always ready
        aw_or = 1'b1;
        for (int i = 0; i < 8; i++) begin
            aw_iv = 1'b1;
            aw_id = mk_aw(32'h1000 + 32'h40 * 32'(i));
            tick();
            check("b2b_valid", 128'(aw_ov), 128'(1));
            check("b2b_addr", 128'(aw_od[61:30]), 128'(32'h1000 + 32'h40 * 32'(i)));
            check("b2b_s_ready", 128'(aw_ir), 128'(1));
        end
        aw_iv = 1'b0;
        tick();
        check("b2b_drained", 128'(aw_ov), 128'(0));

        // Stall: four offered cycles, only two beats fit
        aw_or = 1'b0; acc = 0; k = 0;
        for (int c = 0; c < 4; c++) begin
            aw_iv = 1'b1;
            aw_id = mk_aw(32'h2000 + 32'h40 * 32'(k));
            if (aw_ir) begin acc++; k++; end
            tick();
            if (c >= 1) check("stall_s_ready_low", 128'(aw_ir), 128'(0));
        end
        check("stall_accepted", 128'(acc), 128'(2));
        aw_iv = 1'b0; aw_or = 1'b1;
        #1;
        check("stall_out0", 128'(aw_od[61:30]), 128'(32'h2000));
        tick();
        check("stall_out1_valid", 128'(aw_ov), 128'(1));
        check("stall_out1", 128'(aw_od[61:30]), 128'(32'h2040));
        tick();
        check("stall_empty", 128'(aw_ov), 128'(0));
        aw_or = 1'b0;

        // 1000 R beats under a random 50% downstream ready
        sent = 0; recv = 0; maxocc = 0; simul = 0;
        for (int cyc = 0; cyc < 6000 && recv < 1000; cyc++) begin
            r_iv = (sent < 1000);
            r_id = mk_r(sent);
            r_or = 1'($urandom_range(0, 1));
            #1;
            inx  = r_iv && r_ir;
            outx = r_ov && r_or;
            if (outx) check("r_scoreboard", 128'(r_od), 128'(mk_r(recv)));
            if (inx && outx && (sent - recv) == 1) simul++;
            sent += int'(inx);
            recv += int'(outx);
            if (sent - recv > maxocc) maxocc = sent - recv;
            tick();
        end
        r_iv = 1'b0; r_or = 1'b0;
        check("r_received", 128'(recv), 128'(1000));
        check("r_max_occupancy_le2", 128'(maxocc <= 2), 128'(1));
        check("r_simul_push_pop_seen", 128'(simul > 0), 128'(1));
        tick();

        // wid travels with the W beat
        w_or = 1'b1; w_iv = 1'b1;
        w_id = {4'h7, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b0};
        tick();
        w_iv = 1'b0;
        check("wid_valid", 128'(w_ov), 128'(1));
        check("wid_value", 128'(w_od[41:38]), 128'(4'h7));
        check("wid_wdata", 128'(w_od[37:6]), 128'(32'hA5A5_A5A5));
        tick();
        w_or = 1'b0;

        // W latency per mode: BYPASS 0, FWD 1, REV 0
        d0 = {32'hA5A5_A5A5, 4'hF, 1'b1, 1'b0};
        d1 = {32'h5A5A_5A5A, 4'h3, 1'b0, 1'b1};
        exp_lat = 3'b010;
        for (int g = 0; g < 3; g++) begin
            wmr[g] = 1'b1; wv[g] = 1'b1; wd[g] = d0; lat = -1;
            #1;
            for (int c = 0; c < 4; c++) begin
                if (lat < 0 && wmv[g]) begin
                    lat = c;
                    check($sformatf("mode%0d_data", g), 128'(wmd[g]), 128'(d0));
                end
                accept = wv[g] && wsr[g];
                tick();
                if (accept) wv[g] = 1'b0;
                #1;
            end
            check($sformatf("mode%0d_latency", g), 128'(lat), 128'(exp_lat[g]));
            check($sformatf("mode%0d_drained", g), 128'(wmv[g]), 128'(0));
        end

        // REV stall: ready drops for one cycle only
        wmr[2] = 1'b0; wv[2] = 1'b1; wd[2] = d0;
        #1;
        check("rev_ready_pre", 128'(wsr[2]), 128'(1));
        tick();
        check("rev_ready_stalled", 128'(wsr[2]), 128'(0));
        check("rev_skid_valid", 128'(wmv[2]), 128'(1));
        check("rev_skid_data", 128'(wmd[2]), 128'(d0));
        wmr[2] = 1'b1; wd[2] = d1;
        tick();
        check("rev_ready_back", 128'(wsr[2]), 128'(1));
        check("rev_pass_data", 128'(wmd[2]), 128'(d1));
        tick();
        wv[2] = 1'b0;
        #1;
        check("rev_empty", 128'(wmv[2]), 128'(0));

        // Async reset while B holds two beats
        b_or = 1'b0; b_iv = 1'b1; b_id = mk_b(4'h1);
        tick();
        b_id = mk_b(4'h2);
        tick();
        b_iv = 1'b0;
        check("b_full_valid", 128'(b_ov), 128'(1));
        check("b_full_ready", 128'(b_ir), 128'(0));
        check("b_full_head", 128'(b_od), 128'(mk_b(4'h1)));
        #1 rst_n = 1'b0;
        #1;
        check("b_rst_valid", 128'(b_ov), 128'(0));
        check("b_rst_idle", 128'(idle), 128'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("b_rel_ready", 128'(b_ir), 128'(1));
        b_iv = 1'b1; b_id = mk_b(4'h3); b_or = 1'b1;
        tick();
        b_iv = 1'b0;
        check("b_after_valid", 128'(b_ov), 128'(1));
        check("b_after_bid", 128'(b_od[6:3]), 128'(4'h3));
        tick();
        check("b_after_empty", 128'(b_ov), 128'(0));

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
